apb_inst_fetch: RTL and testbench

- Instruction fetch stage ahead of the pre-fetch buffer; acts as APB master to instruction memory.
- Reads one 32-bit word per transfer, splits it into two 16-bit instructions (`inst1`, `inst2`) and pulses `write` together with the word's address (`PC_out`).
- Handles stall back-pressure and branch redirection so the pre-fetch buffer never loses or receives a stale word.

---
 rtl/apb_inst_fetch_if.sv | 12 +
 rtl/apb_inst_fetch.sv | 129 ++++++++++++
 tb/tb_apb_inst_fetch.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/apb_inst_fetch_if.sv
// apb_inst_fetch_if: APB read channel between the fetch stage and instruction memory.
interface apb_inst_fetch_if #(parameter int ADDR_W = 32);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;
    modport master(output psel, penable, pwrite, paddr, input prdata, pready, pslverr);
    modport slave(input psel, penable, pwrite, paddr, output prdata, pready, pslverr);
endinterface

// File: rtl/apb_inst_fetch.sv
// apb_inst_fetch: APB-master fetch stage delivering two 16-bit instructions per word.
// Define FETCH_SLVERR_HALT_EN to halt in ERR on a slave error instead of delivering zeros.
module apb_inst_fetch #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_flg,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    apb_inst_fetch_if.master  apb,
    output logic [15:0]       inst1,
    output logic [15:0]       inst2,
    output logic              write,
    output logic [ADDR_W-1:0] PC_out,
    output logic              fetch_err
);
    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, ERR} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q, paddr_q, pc_out_q;
    logic [15:0]       inst1_q, inst2_q;
    logic              squash_q, psel_q, penable_q, write_q, err_q;
    logic [ADDR_W-1:0] br_pc, nxt_pc;
    logic [31:0]       rd_word;

    assign br_pc   = br_target & ~ADDR_W'(3);
    assign nxt_pc  = paddr_q + ADDR_W'(4);
    assign rd_word = apb.pslverr ? 32'h0 : apb.prdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            paddr_q   <= RESET_PC;
            pc_out_q  <= '0;
            inst1_q   <= '0;
            inst2_q   <= '0;
            squash_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            write_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (br_valid) pc_q <= br_pc;
                    if (!stall_flg) begin
                        state_q <= SETUP;
                        psel_q  <= 1'b1;
                        paddr_q <= br_valid ? br_pc : pc_q;
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                    if (br_valid) begin
                        pc_q     <= br_pc;
                        squash_q <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (apb.pready && apb.pslverr) err_q <= 1'b1;
                    if (!apb.pready) begin
                        if (br_valid) begin
                            pc_q     <= br_pc;
                            squash_q <= 1'b1;
                        end
`ifdef FETCH_SLVERR_HALT_EN
                    end else if (apb.pslverr) begin
                        state_q   <= ERR;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        squash_q  <= 1'b0;
`endif
                    end else if (br_valid || squash_q) begin
                        // A redirect already owns pc; the completed word is stale.
                        if (br_valid) pc_q <= br_pc;
                        state_q   <= IDLE;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        squash_q  <= 1'b0;
                    end else begin
                        inst1_q   <= rd_word[31:16];
                        inst2_q   <= rd_word[15:0];
                        pc_out_q  <= paddr_q;
                        pc_q      <= nxt_pc;
                        penable_q <= 1'b0;
                        if (stall_flg) begin
                            state_q <= HOLD;
                            psel_q  <= 1'b0;
                        end else begin
                            state_q <= SETUP;
                            write_q <= 1'b1;
                            paddr_q <= nxt_pc;
                        end
                    end
                end
                HOLD: begin
                    if (br_valid) begin
                        pc_q    <= br_pc;
                        state_q <= IDLE;
                    end else if (!stall_flg) begin
                        write_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= state_q;
            endcase
        end
    end

    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.pwrite  = 1'b0;
    assign apb.paddr   = paddr_q;
    assign inst1       = inst1_q;
    assign inst2       = inst2_q;
    assign write       = write_q;
    assign PC_out      = pc_out_q;
    assign fetch_err   = err_q;

    a_write_pulse: assert property (@(posedge clk) disable iff (!rst) write_q |=> !write_q);
    a_setup_access: assert property (@(posedge clk) disable iff (!rst)
        (psel_q && !penable_q) |=> (psel_q && penable_q));
    a_aligned: assert property (@(posedge clk) disable iff (!rst) paddr_q[1:0] == 2'b00);
endmodule

// File: tb/tb_apb_inst_fetch.sv
// tb_apb_inst_fetch: directed scenarios for apb_inst_fetch against a small APB memory model.
module tb_apb_inst_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_flg = 1'b0;
    logic        br_valid = 1'b0;
    logic [31:0] br_target = '0;
    logic [15:0] inst1, inst2;
    logic        write, fetch_err;
    logic [31:0] PC_out;
    logic        rdy = 1'b1;
    logic        err_en = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;

    apb_inst_fetch_if #(.ADDR_W(32)) apb();

    apb_inst_fetch #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .stall_flg(stall_flg), .br_valid(br_valid), .br_target(br_target),
        .apb(apb), .inst1(inst1), .inst2(inst2), .write(write), .PC_out(PC_out), .fetch_err(fetch_err)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'hA1B2_C3D4 : {a[15:0], ~a[15:0]};
    endfunction

    assign apb.prdata  = mem_word(apb.paddr);
    assign apb.pready  = rdy;
    assign apb.pslverr = err_en && apb.psel && apb.penable && (apb.paddr == 32'hC);

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, want finished", $time);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        stall_flg = 1'b0;
        br_valid = 1'b0;
        rdy = 1'b1;
        err_en = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        n_chk++; if (apb.psel !== 1'b0) begin n_fail++; $display("FAIL rst_psel: got %b want 0", apb.psel); end
        n_chk++; if (apb.penable !== 1'b0) begin n_fail++; $display("FAIL rst_penable: got %b want 0", apb.penable); end
        n_chk++; if (apb.pwrite !== 1'b0) begin n_fail++; $display("FAIL rst_pwrite: got %b want 0", apb.pwrite); end
        n_chk++; if (apb.paddr !== 32'h0) begin n_fail++; $display("FAIL rst_paddr: got %h want 0", apb.paddr); end
        n_chk++; if ({inst1, inst2} !== 32'h0) begin n_fail++; $display("FAIL rst_inst: got %h want 0", {inst1, inst2}); end
        n_chk++; if (write !== 1'b0) begin n_fail++; $display("FAIL rst_write: got %b want 0", write); end
        n_chk++; if (PC_out !== 32'h0) begin n_fail++; $display("FAIL rst_pc_out: got %h want 0", PC_out); end
        n_chk++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", fetch_err); end
    endtask

    task automatic test_zero_wait();
        do_reset();
        tick();
        n_chk++; if ({apb.psel, apb.penable} !== 2'b10 || apb.paddr !== 32'h0) begin n_fail++; $display("FAIL zw_setup: got sel/en %b%b addr %h want 10 addr 0", apb.psel, apb.penable, apb.paddr); end
        tick();
        n_chk++; if ({apb.psel, apb.penable, write} !== 3'b110) begin n_fail++; $display("FAIL zw_access: got sel/en/wr %b%b%b want 110", apb.psel, apb.penable, write); end
        tick();
        n_chk++; if (write !== 1'b1) begin n_fail++; $display("FAIL zw_write: got %b want 1", write); end
        n_chk++; if (inst1 !== 16'hA1B2 || inst2 !== 16'hC3D4) begin n_fail++; $display("FAIL zw_data: got %h %h want a1b2 c3d4", inst1, inst2); end
        n_chk++; if (PC_out !== 32'h0) begin n_fail++; $display("FAIL zw_pc_out: got %h want 0", PC_out); end
        n_chk++; if (apb.paddr !== 32'h4 || {apb.psel, apb.penable} !== 2'b10) begin n_fail++; $display("FAIL zw_next: got addr %h sel/en %b%b want 4 10", apb.paddr, apb.psel, apb.penable); end
        tick();
        n_chk++; if (write !== 1'b0) begin n_fail++; $display("FAIL zw_gap: got %b want 0", write); end
        tick();
        n_chk++; if (write !== 1'b1 || PC_out !== 32'h4 || {inst1, inst2} !== 32'h0004_FFFB) begin n_fail++; $display("FAIL zw_second: got wr %b pc %h data %h want 1 4 0004fffb", write, PC_out, {inst1, inst2}); end
    endtask

    task automatic test_wait_states();
        int wr_cnt = 0;
        do_reset();
        rdy = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++; if ({apb.psel, apb.penable, write} !== 3'b110 || apb.paddr !== 32'h0) begin n_fail++; $display("FAIL ws_hold%0d: got sel/en/wr %b%b%b addr %h want 110 addr 0", i, apb.psel, apb.penable, write, apb.paddr); end
        end
        rdy = 1'b1;
        tick();
        n_chk++; if (write !== 1'b1 || PC_out !== 32'h0 || inst1 !== 16'hA1B2) begin n_fail++; $display("FAIL ws_write: got wr %b pc %h inst1 %h want 1 0 a1b2", write, PC_out, inst1); end
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (write === 1'b1) wr_cnt++;
        end
        n_chk++; if (wr_cnt !== 0) begin n_fail++; $display("FAIL ws_single: got %0d extra writes want 0", wr_cnt); end
        rdy = 1'b1;
    endtask

    task automatic test_stall();
        do_reset();
        tick();
        tick();
        stall_flg = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_chk++; if (apb.psel !== 1'b0 || write !== 1'b0) begin n_fail++; $display("FAIL st_hold%0d: got sel %b wr %b want 0 0", i, apb.psel, write); end
        end
        stall_flg = 1'b0;
        tick();
        n_chk++; if (write !== 1'b1 || {inst1, inst2} !== 32'hA1B2_C3D4 || PC_out !== 32'h0) begin n_fail++; $display("FAIL st_release: got wr %b data %h pc %h want 1 a1b2c3d4 0", write, {inst1, inst2}, PC_out); end
        tick();
        tick();
        n_chk++; if (apb.psel !== 1'b1 || apb.paddr !== 32'h4 || write !== 1'b0) begin n_fail++; $display("FAIL st_resume: got sel %b addr %h wr %b want 1 4 0", apb.psel, apb.paddr, write); end
    endtask

    task automatic test_branch();
        do_reset();
        repeat (6) tick();
        br_valid = 1'b1;
        br_target = 32'h0000_0102;
        tick();
        br_valid = 1'b0;
        n_chk++; if (write !== 1'b0 || PC_out !== 32'h4 || apb.psel !== 1'b0) begin n_fail++; $display("FAIL br_drop: got wr %b pc %h sel %b want 0 4 0", write, PC_out, apb.psel); end
        tick();
        n_chk++; if (apb.psel !== 1'b1 || apb.paddr !== 32'h100) begin n_fail++; $display("FAIL br_target: got sel %b addr %h want 1 100", apb.psel, apb.paddr); end
        tick();
        tick();
        n_chk++; if (write !== 1'b1 || PC_out !== 32'h100 || {inst1, inst2} !== 32'h0100_FEFF) begin n_fail++; $display("FAIL br_deliver: got wr %b pc %h data %h want 1 100 0100feff", write, PC_out, {inst1, inst2}); end
        br_valid = 1'b1;
        br_target = 32'h0000_0203;
        tick();
        br_valid = 1'b0;
        tick();
        n_chk++; if (write !== 1'b0 || PC_out !== 32'h100) begin n_fail++; $display("FAIL br_squash: got wr %b pc %h want 0 100", write, PC_out); end
        tick();
        n_chk++; if (apb.psel !== 1'b1 || apb.paddr !== 32'h200) begin n_fail++; $display("FAIL br_squash_target: got sel %b addr %h want 1 200", apb.psel, apb.paddr); end
    endtask

    task automatic test_slverr();
        do_reset();
        err_en = 1'b1;
        repeat (9) tick();
        n_chk++; if (fetch_err !== 1'b1) begin n_fail++; $display("FAIL se_err: got %b want 1", fetch_err); end
`ifdef FETCH_SLVERR_HALT_EN
        for (int i = 0; i < 5; i++) begin
            n_chk++; if (apb.psel !== 1'b0 || write !== 1'b0) begin n_fail++; $display("FAIL se_halt%0d: got sel %b wr %b want 0 0", i, apb.psel, write); end
            tick();
        end
`else
        n_chk++; if (write !== 1'b1 || {inst1, inst2} !== 32'h0 || PC_out !== 32'hC) begin n_fail++; $display("FAIL se_zero: got wr %b data %h pc %h want 1 0 c", write, {inst1, inst2}, PC_out); end
        n_chk++; if (apb.paddr !== 32'h10) begin n_fail++; $display("FAIL se_next: got %h want 10", apb.paddr); end
        tick();
        tick();
        n_chk++; if (write !== 1'b1 || PC_out !== 32'h10 || fetch_err !== 1'b1) begin n_fail++; $display("FAIL se_continue: got wr %b pc %h err %b want 1 10 1", write, PC_out, fetch_err); end
`endif
        err_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (3) tick();
        rdy = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        n_chk++; if ({apb.psel, apb.penable, write} !== 3'b000 || apb.paddr !== 32'h0) begin n_fail++; $display("FAIL rm_bus: got sel/en/wr %b%b%b addr %h want 000 0", apb.psel, apb.penable, write, apb.paddr); end
        n_chk++; if ({inst1, inst2} !== 32'h0 || PC_out !== 32'h0) begin n_fail++; $display("FAIL rm_data: got %h pc %h want 0 0", {inst1, inst2}, PC_out); end
        rdy = 1'b1;
        tick();
        rst = 1'b1;
        repeat (3) tick();
        n_chk++; if (write !== 1'b1 || PC_out !== 32'h0 || inst1 !== 16'hA1B2) begin n_fail++; $display("FAIL rm_refetch: got wr %b pc %h inst1 %h want 1 0 a1b2", write, PC_out, inst1); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_branch();
        test_slverr();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
